// File: rtl/conv3x3_mac.sv
// conv3x3_mac
//   Serial 3x3 convolution MAC. A start pulse latches a nine-pixel window and
//   nine signed coefficients, accumulates one tap per clock, then scales,
//   clamps and emits one output pixel with its result-BRAM write address.
//   A new window is accepted every 9 clocks (back-to-back start in OUT).
//
// Parameters
//   SHIFT       arithmetic right shift applied to the accumulator before clamping
//   OUT_PIXELS  output pixels per frame (out_addr wrap point)
//   ADDR_W      out_addr width, 2^ADDR_W >= OUT_PIXELS
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle pulse, window/kernel valid this cycle
//   window      9 unsigned pixels, byte i at [8i+7:8i], byte 0 oldest
//   kernel      9 signed coefficients, coef i pairs with window byte i
//   busy        high while a start would be ignored (MAC state)
//   pixel_out   scaled, clamped result (held between results)
//   out_valid   one-cycle pulse, pixel_out/out_addr valid
//   out_addr    result BRAM write address (held between results)
//   frame_done  one-cycle pulse with out_valid on the last pixel of a frame
//
// Build option
//   CONV_ABS_RESULT_EN  when defined, the output stage uses the accumulator
//                       magnitude (|acc| >>> SHIFT, saturated to 255) instead
//                       of clamping negative results to 0.
//
// state | meaning
// IDLE  | waiting for start
// MAC   | accumulating taps 1..8
// OUT   | emit result; may accept the next start on the same edge

module conv3x3_mac #(
  parameter int SHIFT      = 0,
  parameter int OUT_PIXELS = 16384,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [71:0]       window,
  input  logic [71:0]       kernel,
  output logic              busy,
  output logic [7:0]        pixel_out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_PIXELS - 1);

  logic [1:0]              state_q, state_d;
  logic [8:0][7:0]         win_q, win_d;
  logic [8:0][7:0]         ker_q, ker_d;
  logic signed [19:0]      acc_q, acc_d;
  logic [3:0]              tap_q, tap_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [7:0]              pix_q, pix_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    valid_q, valid_d;
  logic                    fd_q, fd_d;

  logic                    take_start;
  logic signed [19:0]      mag;
  logic signed [19:0]      shifted;
  logic [7:0]              clamped;

  // Pixel is zero-extended, coefficient sign-extended; the 17-bit signed
  // product always fits, so truncation of the 17-bit multiply is exact.
  function automatic logic signed [19:0] tap_product(input logic [7:0] p,
                                                      input logic [7:0] c);
    logic signed [16:0] pe;
    logic signed [16:0] ce;
    logic signed [16:0] prod;
    pe   = {9'b0, p};
    ce   = {{9{c[7]}}, c};
    prod = pe * ce;
    return {{3{prod[16]}}, prod};
  endfunction

  always_comb begin
`ifdef CONV_ABS_RESULT_EN
    mag = acc_q[19] ? -acc_q : acc_q;
`else
    mag = acc_q;
`endif
    shifted = mag >>> SHIFT;
    if (shifted < 20'sd0)
      clamped = 8'd0;
    else if (shifted > 20'sd255)
      clamped = 8'd255;
    else
      clamped = shifted[7:0];
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ker_d      = ker_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    wr_ptr_d   = wr_ptr_q;
    pix_d      = pix_q;
    addr_d     = addr_q;
    valid_d    = 1'b0;
    fd_d       = 1'b0;
    take_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) take_start = 1'b1;
      end
      S_MAC: begin
        acc_d = acc_q + tap_product(win_q[tap_q], ker_q[tap_q]);
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'd8) state_d = S_OUT;
      end
      S_OUT: begin
        pix_d    = clamped;
        addr_d   = wr_ptr_q;
        valid_d  = 1'b1;
        fd_d     = (wr_ptr_q == LAST_ADDR);
        wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        if (start) take_start = 1'b1;
        else       state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Tap 0 is taken straight from the inputs so the MAC needs only 8 more
    // edges, giving the 9-clock window period.
    if (take_start) begin
      win_d   = window;
      ker_d   = kernel;
      acc_d   = tap_product(window[7:0], kernel[7:0]);
      tap_d   = 4'd1;
      state_d = S_MAC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      ker_q    <= '0;
      acc_q    <= '0;
      tap_q    <= '0;
      wr_ptr_q <= '0;
      pix_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      ker_q    <= ker_d;
      acc_q    <= acc_d;
      tap_q    <= tap_d;
      wr_ptr_q <= wr_ptr_d;
      pix_q    <= pix_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      fd_q     <= fd_d;
    end
  end

  assign busy       = (state_q == S_MAC);
  assign pixel_out  = pix_q;
  assign out_addr   = addr_q;
  assign out_valid  = valid_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
module tb_conv3x3_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start3 = 1'b0;
  logic [71:0] window = '0;
  logic [71:0] kernel = '0;

  logic        busy0, ov0, fd0;
  logic [7:0]  pix0;
  logic [13:0] addr0;
  logic        busy3, ov3, fd3;
  logic [7:0]  pix3;
  logic [13:0] addr3;

  int checks = 0;
  int errors = 0;

  localparam logic [71:0] K_ID  = 72'h00_00_00_00_01_00_00_00_00;
  localparam logic [71:0] W_RAMP = 72'h90_80_70_60_50_40_30_20_10;

  always #5 clk = ~clk;

  // SHIFT=0 with a 4-pixel frame for wrap tests
  conv3x3_mac #(.SHIFT(0), .OUT_PIXELS(4), .ADDR_W(14)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .window(window), .kernel(kernel),
    .busy(busy0), .pixel_out(pix0), .out_valid(ov0), .out_addr(addr0),
    .frame_done(fd0)
  );

  conv3x3_mac #(.SHIFT(3), .OUT_PIXELS(16384), .ADDR_W(14)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .window(window), .kernel(kernel),
    .busy(busy3), .pixel_out(pix3), .out_valid(ov3), .out_addr(addr3),
    .frame_done(fd3)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one start, then observes until out_valid (bounded). lat is the
  // number of falling edges after the start edge, -1 if none was seen.
  task automatic do_window(input logic [71:0] w, input logic [71:0] k,
                           input bit sel, output int lat, output int bcnt,
                           output logic [7:0] pix, output logic [13:0] addr,
                           output logic fd);
    @(negedge clk);
    window = w;
    kernel = k;
    if (sel) start3 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start3 = 1'b0;
    window = ~w;
    kernel = ~k;
    lat = -1; bcnt = 0; pix = '0; addr = '0; fd = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (sel ? busy3 : busy0) bcnt++;
      if (sel ? ov3 : ov0) begin
        lat  = c;
        pix  = sel ? pix3 : pix0;
        addr = sel ? addr3 : addr0;
        fd   = sel ? fd3 : fd0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pix0 !== 8'd0)   begin errors++; $display("FAIL reset_pix got %0h exp 0", pix0); end
    checks++; if (addr0 !== 14'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", addr0); end
    checks++; if (ov0 !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b exp 0", ov0); end
    checks++; if (fd0 !== 1'b0)    begin errors++; $display("FAIL reset_fd got %b exp 0", fd0); end
    checks++; if (busy0 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b exp 00", busy0, busy3); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int lat, bcnt; logic [7:0] pix; logic [13:0] addr; logic fd;
    apply_reset();
    do_window(W_RAMP, K_ID, 1'b0, lat, bcnt, pix, addr, fd);
    checks++; if (lat !== 9)      begin errors++; $display("FAIL id_latency got %0d exp 9", lat); end
    checks++; if (bcnt !== 8)     begin errors++; $display("FAIL id_busy_cycles got %0d exp 8", bcnt); end
    checks++; if (pix !== 8'h50)  begin errors++; $display("FAIL id_pix got %0h exp 50", pix); end
    checks++; if (addr !== 14'd0) begin errors++; $display("FAIL id_addr got %0h exp 0", addr); end
    checks++; if (fd !== 1'b0)    begin errors++; $display("FAIL id_fd got %b exp 0", fd); end
    @(negedge clk);
    checks++; if (ov0 !== 1'b0)   begin errors++; $display("FAIL id_pulse got %b exp 0", ov0); end
    checks++; if (pix0 !== 8'h50) begin errors++; $display("FAIL id_hold got %0h exp 50", pix0); end
  endtask

  task automatic test_saturation();
    int lat, bcnt; logic [7:0] pix; logic [13:0] addr; logic fd;
    apply_reset();
    // 9*255 = 2295, >>>3 = 286 -> 255
    do_window({9{8'hFF}}, {9{8'h01}}, 1'b1, lat, bcnt, pix, addr, fd);
    checks++; if (lat !== 9)     begin errors++; $display("FAIL sat_latency got %0d exp 9", lat); end
    checks++; if (pix !== 8'hFF) begin errors++; $display("FAIL sat_pix got %0h exp ff", pix); end
    // 9*8 = 72, >>>3 = 9
    do_window({9{8'h08}}, {9{8'h01}}, 1'b1, lat, bcnt, pix, addr, fd);
    checks++; if (pix !== 8'd9)   begin errors++; $display("FAIL shift_pix got %0d exp 9", pix); end
    checks++; if (addr !== 14'd1) begin errors++; $display("FAIL shift_addr got %0d exp 1", addr); end
  endtask

  task automatic test_negative();
    int lat, bcnt; logic [7:0] pix; logic [13:0] addr; logic fd;
    logic [7:0] exp_neg;
`ifdef CONV_ABS_RESULT_EN
    exp_neg = 8'd90;
`else
    exp_neg = 8'd0;
`endif
    apply_reset();
    do_window({9{8'd10}}, {9{8'hFF}}, 1'b0, lat, bcnt, pix, addr, fd);
    checks++; if (pix !== exp_neg) begin errors++; $display("FAIL neg_pix got %0d exp %0d", pix, exp_neg); end
    // mixed signs with a large pixel on a negative tap: -200-100+200+300 = 200
    do_window(72'h64_28_99_1E_32_14_77_0A_C8, 72'h03_FF_00_FF_04_FF_00_FF_FF,
              1'b0, lat, bcnt, pix, addr, fd);
    checks++; if (pix !== 8'd200) begin errors++; $display("FAIL mixed_pix got %0d exp 200", pix); end
  endtask

  task automatic test_back_to_back();
    int exp_c[3] = '{10, 19, 28};
    logic [7:0] exp_p[3] = '{8'h50, 8'h33, 8'h44};
    int nval = 0;
    apply_reset();
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (ov0) begin
        nval++;
        if (nval <= 3) begin
          checks++; if (c !== exp_c[nval-1]) begin errors++; $display("FAIL b2b_time%0d got %0d exp %0d", nval, c, exp_c[nval-1]); end
          checks++; if (pix0 !== exp_p[nval-1]) begin errors++; $display("FAIL b2b_pix%0d got %0h exp %0h", nval, pix0, exp_p[nval-1]); end
          checks++; if (addr0 !== 14'(nval-1)) begin errors++; $display("FAIL b2b_addr%0d got %0d exp %0d", nval, addr0, nval-1); end
        end
      end
      start0 = 1'b0;
      window = {9{8'hAA}};
      kernel = {9{8'h7F}};
      case (c)
        0:  begin start0 = 1'b1; window = W_RAMP;       kernel = K_ID; end
        3:  begin start0 = 1'b1; window = {9{8'hEE}};   kernel = K_ID; end
        9:  begin start0 = 1'b1; window = {9{8'h33}};   kernel = K_ID; end
        18: begin start0 = 1'b1; window = {9{8'h44}};   kernel = K_ID; end
        default: ;
      endcase
    end
    start0 = 1'b0;
    checks++; if (nval !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", nval); end
  endtask

  task automatic test_frame_wrap();
    int lat, bcnt; logic [7:0] pix; logic [13:0] addr; logic fd;
    logic [7:0] v;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      v = 8'(8'h11 * (i + 1));
      do_window({9{v}}, K_ID, 1'b0, lat, bcnt, pix, addr, fd);
      checks++; if (addr !== 14'(i % 4)) begin errors++; $display("FAIL wrap_addr%0d got %0d exp %0d", i, addr, i % 4); end
      checks++; if (fd !== (i == 3))     begin errors++; $display("FAIL wrap_fd%0d got %b exp %b", i, fd, (i == 3)); end
      checks++; if (pix !== v)           begin errors++; $display("FAIL wrap_pix%0d got %0h exp %0h", i, pix, v); end
    end
  endtask

  task automatic test_reset_mid_mac();
    int lat, bcnt; logic [7:0] pix; logic [13:0] addr; logic fd;
    int seen = 0;
    apply_reset();
    do_window(W_RAMP, K_ID, 1'b0, lat, bcnt, pix, addr, fd);
    checks++; if (addr !== 14'd0) begin errors++; $display("FAIL rmid_first_addr got %0d exp 0", addr); end
    @(negedge clk);
    window = W_RAMP; kernel = K_ID; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (pix0 !== 8'd0)   begin errors++; $display("FAIL rmid_pix got %0h exp 0", pix0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL rmid_busy got %b exp 0", busy0); end
    checks++; if (addr0 !== 14'd0 || ov0 !== 1'b0 || fd0 !== 1'b0) begin errors++; $display("FAIL rmid_outs got addr %0d v %b fd %b exp 0 0 0", addr0, ov0, fd0); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ov0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_valid got %0d exp 0", seen); end
    do_window(W_RAMP, K_ID, 1'b0, lat, bcnt, pix, addr, fd);
    checks++; if (lat !== 9)      begin errors++; $display("FAIL rmid_latency got %0d exp 9", lat); end
    checks++; if (addr !== 14'd0) begin errors++; $display("FAIL rmid_addr got %0d exp 0", addr); end
    checks++; if (pix !== 8'h50)  begin errors++; $display("FAIL rmid_result got %0h exp 50", pix); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_negative();
    test_back_to_back();
    test_frame_wrap();
    test_reset_mid_mac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Downstream consumer of the 72-bit 3x3 window shift register.
- On a start pulse it latches the nine-pixel window and nine signed kernel coefficients, then runs a serial multiply-accumulate, one tap per clock.
- It scales, clamps and emits one 8-bit output pixel with a write address for the result BRAM.
- It accepts a new window every 9 clocks, matching the upstream fill rate.

Parameters:
- SHIFT, 0: arithmetic right shift applied to the accumulator before clamping (kernel normalisation).
- OUT_PIXELS, 16384: output pixels per frame; sets the out_addr wrap point.
- ADDR_W, 14: width of out_addr; must satisfy 2^ADDR_W >= OUT_PIXELS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; window is complete and valid this cycle.
- window  in  72  pixels, unsigned; byte i at [8i+7:8i], byte 0 oldest, byte 8 newest.
- kernel  in  72  coefficients, signed two's complement; coef i at [8i+7:8i] pairs with window byte i.
- busy  out  1  high while a start would be ignored.
- pixel_out  out  8  scaled, clamped result.
- out_valid  out  1  one-cycle pulse; pixel_out and out_addr are valid.
- out_addr  out  ADDR_W  result BRAM write address for pixel_out.
- frame_done  out  1  one-cycle pulse, coincident with out_valid, on the last pixel of a frame.

Behaviour:
- Reset (async, rst=1): state=IDLE; acc, tap counter, wr_ptr, pixel_out, out_addr = 0; out_valid, frame_done, busy = 0.
- States: IDLE, MAC, OUT.
- IDLE: on an edge with start=1:
  - latch window and kernel into internal registers;
  - acc <= p0*c0; tap <= 1; go to MAC.
- MAC:
  - each edge: acc <= acc + p[tap]*c[tap]; tap <= tap+1.
  - after tap 8 is accumulated (8 edges after the start edge), go to OUT.
- OUT, on the next edge:
  - pixel_out <= clamp(acc >>> SHIFT);
  - out_addr <= wr_ptr; out_valid <= 1;
  - frame_done <= (wr_ptr == OUT_PIXELS-1);
  - wr_ptr <= (wr_ptr == OUT_PIXELS-1) ? 0 : wr_ptr+1.
  - if start=1 on this same edge, perform the IDLE start action and go to MAC (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge N; out_valid high for one cycle following edge N+9. Throughput: one window per 9 clocks.
- busy = 1 in MAC only; 0 in IDLE and OUT.
  - start while busy is ignored: no latch, no effect on the running accumulation.
- Arithmetic:
  - product = unsigned 8-bit pixel (zero-extended to 9 bits) times signed 8-bit coefficient, giving 17-bit signed.
  - acc is 20-bit signed; worst case ±293760, so no overflow is possible.
- Clamp: shifted value < 0 gives 0; > 255 gives 255; otherwise its low 8 bits.
- pixel_out and out_addr hold their values between results. out_valid and frame_done are 0 except for the pulse cycle.
- window and kernel are sampled only on the start edge; upstream may shift freely afterwards.
- Reset mid-operation: the calculation is abandoned, no out_valid is produced, and wr_ptr returns to 0.

Optional Feature:
- Macro: CONV_ABS_RESULT_EN.
- Defined: the OUT stage uses |acc| >>> SHIFT (magnitude), then saturates to 255. Used for edge-detection kernels such as Sobel and Laplacian.
- Undefined: negative results clamp to 0 as specified above.
- No other behaviour, latency or port changes.

Test Plan:
- Identity: kernel coef4=1, others 0; SHIFT=0; window bytes 0x10,0x20,...,0x90; start at edge N -> out_valid one cycle after edge N+9, pixel_out=0x50, out_addr=0, busy high for 8 cycles.
- Saturation: all coef=1, all pixels 0xFF, SHIFT=3 -> sum 2295, shifted 286 -> pixel_out=0xFF.
- Negative: all coef=-1 (0xFF), all pixels 10, SHIFT=0 -> pixel_out=0. With CONV_ABS_RESULT_EN defined -> pixel_out=90.
- Back-to-back: three starts spaced exactly 9 clocks, plus an extra start 3 clocks after the first -> exactly three out_valid pulses spaced 9 clocks, out_addr 0,1,2; the extra start has no effect.
- Frame wrap: OUT_PIXELS=4, five windows -> frame_done high only with the 4th out_valid (out_addr=3); the 5th result has out_addr=0.
- Reset mid-MAC: assert rst 4 clocks after start -> all outputs 0 immediately, no out_valid. Next start yields out_addr=0 with a correct result.
